// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// Request bundle, FSM states and the address-window helper.
package dmem_responder_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_STRB_W = 4;

    localparam logic [MEM_ADDR_W-1:0] dmem_base_addr   = 32'h0010_0000;
    localparam int                    dmem_wait_states = 1;

    typedef struct packed {
        logic                  valid;
        logic                  instr;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_STRB_W-1:0] wstrb;
    } mem_in_type;

    typedef struct packed {
        logic                  ready;
        logic [MEM_DATA_W-1:0] rdata;
        logic                  error;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_resp_state_type;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_STRB_W-1:0] wstrb;
        logic                  instr;
        logic                  valid;
    } dmem_req_type;

    // Base is aligned to the window size, so an address below the base
    // wraps to a huge offset and falls out of range as well.
    function automatic logic dmem_in_range(
        input logic [MEM_ADDR_W-1:0] addr,
        input logic [MEM_ADDR_W-1:0] base,
        input int                    abits
    );
        logic [MEM_ADDR_W-1:0] off;
        off = addr - base;
        return (off >> (abits + 2)) == '0;
    endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Word-organised SRAM with per-byte write enables.
// Synchronous read: data appears the cycle after an enabled access.
module dmem_sram_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [MEM_STRB_W-1:0] i_we,
    input  logic [ADDR_BITS-1:0]  i_addr,
    input  logic [MEM_DATA_W-1:0] i_wdata,
    output logic [MEM_DATA_W-1:0] o_rdata
);

    logic [MEM_DATA_W-1:0] r_mem [2**ADDR_BITS];
    logic [MEM_DATA_W-1:0] r_q;

    // Byte-lane writes plus a registered read of the addressed word
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < MEM_STRB_W; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: latches requests, inserts wait states,
// buffers one extra request and answers from an on-chip SRAM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int                    ADDR_BITS   = 10,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = dmem_base_addr,
    parameter int                    WAIT_STATES = dmem_wait_states
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic [MEM_STRB_W-1:0] mem_wstrb,
    output logic                  mem_ready,
    output logic [MEM_DATA_W-1:0] mem_rdata,
    output logic                  mem_error,
    output logic                  overflow
);

    localparam dmem_resp_state_type START_ST =
        (WAIT_STATES == 0) ? RESP : WAIT;
    localparam logic [3:0] CNT_LOAD =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_resp_state_type   r_state;
    dmem_req_type          r_act;
    dmem_req_type          r_pend;
    logic [3:0]            r_cnt;
    logic                  r_ready;
    logic                  r_error;
    logic                  r_ovf;
    logic [MEM_DATA_W-1:0] r_rdata;

    dmem_req_type          w_in;
    dmem_req_type          w_new;
    dmem_req_type          w_sreq;
    logic                  w_take;
    logic                  w_issue;
    logic                  w_sreq_rng;
    logic                  w_act_rng;
    logic                  w_sram_en;
    logic [MEM_STRB_W-1:0] w_sram_we;
    logic [MEM_ADDR_W-1:0] w_off;
    logic [ADDR_BITS-1:0]  w_sidx;
    logic [MEM_DATA_W-1:0] w_sram_q;
    logic                  w_unused;

    assign w_in = '{
        addr:  mem_addr,
        wdata: mem_wdata,
        wstrb: mem_wstrb,
        instr: mem_instr,
        valid: mem_valid
    };

    // Select the request whose SRAM access happens this cycle: the one
    // that will sit in RESP next, so read data lines up with mem_ready.
    always_comb begin
        w_new   = r_pend.valid ? r_pend : w_in;
        w_take  = 1'b0;
        w_issue = 1'b0;
        w_sreq  = w_new;
        unique case (r_state)
            IDLE: w_take = mem_valid;
            RESP: w_take = r_pend.valid | mem_valid;
            default: w_take = 1'b0;
        endcase
        if (r_state == WAIT) begin
            w_sreq  = r_act;
            w_issue = (r_cnt == 4'd0);
        end else begin
            w_issue = (WAIT_STATES == 0) && w_take;
        end
    end

    assign w_sreq_rng = dmem_in_range(w_sreq.addr, BASE_ADDR, ADDR_BITS);
    assign w_act_rng  = dmem_in_range(r_act.addr, BASE_ADDR, ADDR_BITS);
    assign w_off      = w_sreq.addr - BASE_ADDR;
    assign w_sidx     = w_off[ADDR_BITS+1:2];
    assign w_sram_en  = w_issue & w_sreq_rng;
    assign w_sram_we  = w_sreq.wstrb & {MEM_STRB_W{w_sram_en}};
    assign w_unused   = ^{r_act.instr, r_act.valid, w_off};

    dmem_sram_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_sram (
        .clk    (clk),
        .i_en   (w_sram_en),
        .i_we   (w_sram_we),
        .i_addr (w_sidx),
        .i_wdata(w_sreq.wdata),
        .o_rdata(w_sram_q)
    );

    // Request FSM, pending buffer, wait counter and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_act   <= '0;
            r_pend  <= '0;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= '0;
            unique case (r_state)
                IDLE: begin
                    if (mem_valid) begin
                        r_act   <= w_in;
                        r_state <= START_ST;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                    if (mem_valid) begin
                        if (!r_pend.valid) begin
                            r_pend <= w_in;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_ready <= 1'b1;
                    r_error <= ~w_act_rng;
                    if (w_act_rng && (r_act.wstrb == '0)) begin
                        r_rdata <= w_sram_q;
                    end
                    if (w_take) begin
                        r_act   <= w_new;
                        r_state <= START_ST;
                        r_cnt   <= CNT_LOAD;
                    end else begin
                        r_state <= IDLE;
                    end
                    // Promotion frees the slot, so a new strobe refills it.
                    if (r_pend.valid) begin
                        r_pend <= w_in;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign mem_error = r_error;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with
// one, zero and two wait states.
module tb_dmem_responder;

    localparam int WS0 = 1;
    localparam int WS1 = 0;
    localparam int WS2 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mv  [3];
    logic        mi  [3];
    logic [31:0] ma  [3];
    logic [31:0] mw  [3];
    logic [3:0]  ms  [3];
    logic        rdy [3];
    logic [31:0] rd  [3];
    logic        err [3];
    logic        ovf [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_STATES(WS0)) u_ws1 (
        .clk(clk), .rst(rst),
        .mem_valid(mv[0]), .mem_instr(mi[0]), .mem_addr(ma[0]),
        .mem_wdata(mw[0]), .mem_wstrb(ms[0]),
        .mem_ready(rdy[0]), .mem_rdata(rd[0]),
        .mem_error(err[0]), .overflow(ovf[0])
    );

    dmem_responder #(.WAIT_STATES(WS1)) u_ws0 (
        .clk(clk), .rst(rst),
        .mem_valid(mv[1]), .mem_instr(mi[1]), .mem_addr(ma[1]),
        .mem_wdata(mw[1]), .mem_wstrb(ms[1]),
        .mem_ready(rdy[1]), .mem_rdata(rd[1]),
        .mem_error(err[1]), .overflow(ovf[1])
    );

    dmem_responder #(.WAIT_STATES(WS2)) u_ws2 (
        .clk(clk), .rst(rst),
        .mem_valid(mv[2]), .mem_instr(mi[2]), .mem_addr(ma[2]),
        .mem_wdata(mw[2]), .mem_wstrb(ms[2]),
        .mem_ready(rdy[2]), .mem_rdata(rd[2]),
        .mem_error(err[2]), .overflow(ovf[2])
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t vt [12];

    function automatic int ws_of(input int i);
        return (i == 0) ? WS0 : ((i == 1) ? WS1 : WS2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // Entered #1 after a clock edge with the instance idle.
    task automatic do_req(input int i, input string nm,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] ed,
                          input logic ee);
        int lat;
        mv[i] = 1'b1;
        ma[i] = a;
        mw[i] = d;
        ms[i] = s;
        @(posedge clk); #1;
        mv[i] = 1'b0;
        lat = 99;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (rdy[i]) begin
                lat = k;
                break;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'(ws_of(i) + 1));
        chk({nm, " rdata"}, rd[i], ed);
        chk({nm, " error"}, 32'(err[i]), 32'(ee));
    endtask

    initial begin
        logic [31:0] ba [4];
        logic [31:0] bd [4];
        logic [3:0]  bs [4];
        logic [31:0] be [4];
        logic [31:0] got [2];
        int n;

        vt[0]  = '{32'h0010_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        vt[1]  = '{32'h0010_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{32'h0010_0013, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vt[3]  = '{32'h0010_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
        vt[4]  = '{32'h0010_0020, 32'h0000_00AA, 4'h1, 32'h0, 1'b0};
        vt[5]  = '{32'h0010_0022, 32'h00BB_0000, 4'h4, 32'h0, 1'b0};
        vt[6]  = '{32'h0010_0020, 32'h0, 4'h0, 32'h11BB_33AA, 1'b0};
        vt[7]  = '{32'h0010_0FFC, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0};
        vt[8]  = '{32'h000F_FFFC, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[9]  = '{32'h000F_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        vt[10] = '{32'h0010_0FFC, 32'h0, 4'h0, 32'h5A5A_5A5A, 1'b0};
        vt[11] = '{32'h0010_1000, 32'h0, 4'h0, 32'h0, 1'b1};

        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0;
            mi[i] = 1'b0;
            ma[i] = '0;
            mw[i] = '0;
            ms[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 32'(rdy[0]), 32'd0);
        chk("reset rdata", rd[0], 32'd0);
        chk("reset error", 32'(err[0]), 32'd0);
        chk("reset overflow", 32'(ovf[2]), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Table: single transactions on the one-wait-state instance
        for (int v = 0; v < 12; v++) begin
            do_req(0, $sformatf("vec%0d", v), vt[v].a, vt[v].d,
                   vt[v].s, vt[v].ed, vt[v].ee);
        end

        // Zero wait states: a new request on every response cycle
        ba = '{32'h0010_0040, 32'h0010_0040, 32'h0010_0040, 32'h0010_0040};
        bd = '{32'hCAFE_F00D, 32'h0, 32'h0000_1234, 32'h0};
        bs = '{4'hF, 4'h0, 4'h3, 4'h0};
        be = '{32'h0, 32'hCAFE_F00D, 32'h0, 32'hCAFE_1234};
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                mv[1] = 1'b1;
                ma[1] = ba[k];
                mw[1] = bd[k];
                ms[1] = bs[k];
            end else begin
                mv[1] = 1'b0;
            end
            @(posedge clk); #1;
            if (k >= 1 && k <= 4) begin
                chk($sformatf("b2b ready%0d", k), 32'(rdy[1]), 32'd1);
                chk($sformatf("b2b rdata%0d", k), rd[1], be[k-1]);
            end else begin
                chk($sformatf("b2b idle%0d", k), 32'(rdy[1]), 32'd0);
                chk($sformatf("b2b idle rdata%0d", k), rd[1], 32'd0);
            end
        end

        // Preload, then three back-to-back pulses with two wait states
        do_req(2, "pre0", 32'h0010_0000, 32'h1111_1111, 4'hF, 32'h0, 1'b0);
        do_req(2, "pre1", 32'h0010_0004, 32'h2222_2222, 4'hF, 32'h0, 1'b0);
        do_req(2, "pre2", 32'h0010_0008, 32'h3333_3333, 4'hF, 32'h0, 1'b0);
        got = '{32'h0, 32'h0};
        n = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 3) begin
                mv[2] = 1'b1;
                ma[2] = 32'h0010_0000 + 32'(4 * k);
                ms[2] = 4'h0;
            end else begin
                mv[2] = 1'b0;
            end
            @(posedge clk); #1;
            if (rdy[2]) begin
                if (n < 2) got[n] = rd[2];
                n++;
            end
            if (k == 1) chk("burst ovf before", 32'(ovf[2]), 32'd0);
            if (k == 2) chk("burst ovf set", 32'(ovf[2]), 32'd1);
        end
        chk("burst responses", 32'(n), 32'd2);
        chk("burst data0", got[0], 32'h1111_1111);
        chk("burst data1", got[1], 32'h2222_2222);
        chk("burst ovf sticky", 32'(ovf[2]), 32'd1);

        // Reset while in WAIT with a pending request
        mv[2] = 1'b1;
        ma[2] = 32'h0010_0000;
        ms[2] = 4'h0;
        @(posedge clk); #1;
        ma[2] = 32'h0010_0004;
        @(posedge clk); #1;
        mv[2] = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst ovf cleared", 32'(ovf[2]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rdy[2]) n++;
        end
        chk("rst no response", 32'(n), 32'd0);
        chk("rst ovf stays 0", 32'(ovf[2]), 32'd0);

        // Memory contents survive reset
        do_req(2, "post rst ws2", 32'h0010_0004, 32'h0, 4'h0,
               32'h2222_2222, 1'b0);
        do_req(0, "post rst ws1", 32'h0010_0020, 32'h0, 4'h0,
               32'h11BB_33AA, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
